// File: rtl/enviar_dac.sv
// -----------------------------------------------------------------------------
// enviar_dac
//
// Serialises one 12-bit sample into a 16-bit frame for a serial DAC. The frame
// is sent MSB first and framed by an active-low SYNC. All logic runs on the
// rising edge of clock44kHz. The DAC samples datoDAC on the falling edge, so
// every bit is stable for a full half period on each side of that edge.
//
// Frame layout:
//   [15:14] = 00  don't care
//   [13:12] = 00  normal mode, no power-down
//   [11:0]  = captured sample
//
// Ports:
//   clock44kHz  in   1   sole clock
//   reset       in   1   synchronous, active-high reset
//   inicio      in   1   level request to start a frame; sampled only in IDLE
//   dato_in     in  12   sample, captured on the accepting edge
//   datoDAC     out  1   serial data to the DAC, MSB first
//   SYNC_out    out  1   active-low frame sync / chip select
//   dout        out 16   frame captured at acceptance, held until next frame
//   ocupado     out  1   high from acceptance through the last data bit
//   listo       out  1   one-cycle pulse marking frame completion
//
// Build option:
//   ENVIAR_DAC_OFFSET_EN  when defined, dato_in is treated as two's complement
//                         and converted to offset binary by inverting bit 11.
//                         When undefined, dato_in is framed unchanged.
// -----------------------------------------------------------------------------
module enviar_dac (
  input  logic        clock44kHz,
  input  logic        reset,
  input  logic        inicio,
  input  logic [11:0] dato_in,
  output logic        datoDAC,
  output logic        SYNC_out,
  output logic [15:0] dout,
  output logic        ocupado,
  output logic        listo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENVIA = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  bit_count;
  logic [14:0] shift_reg;
  logic [11:0] sample_coded;
  logic [15:0] frame_next;

  // Input coding: optionally convert two's complement to offset binary so
  // that zero maps to mid-scale on a unipolar DAC.
`ifdef ENVIAR_DAC_OFFSET_EN
  always_comb begin
    sample_coded = {~dato_in[11], dato_in[10:0]};
  end
`else
  always_comb begin
    sample_coded = dato_in;
  end
`endif

  // Control bits are fixed at zero: normal operating mode, no power-down.
  always_comb begin
    frame_next = {4'b0000, sample_coded};
  end

  // Frame sequencer. Bit 15 goes out on the accepting edge; the remaining 15
  // bits come out of shift_reg one per edge while bit_count tracks the bit
  // index. The exit to FIN is taken exactly at count 15, so the counter never
  // reaches a 17th bit. FIN is a mandatory extra idle cycle, which keeps SYNC
  // high for at least two cycles between frames and gives an 18-cycle period
  // when inicio is held high.
  always_ff @(posedge clock44kHz) begin
    if (reset) begin
      state     <= IDLE;
      SYNC_out  <= 1'b1;
      datoDAC   <= 1'b0;
      dout      <= 16'h0000;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
      bit_count <= 4'd0;
      shift_reg <= 15'd0;
    end else begin
      case (state)
        IDLE: begin
          SYNC_out  <= 1'b1;
          datoDAC   <= 1'b0;
          ocupado   <= 1'b0;
          listo     <= 1'b0;
          bit_count <= 4'd0;
          if (inicio) begin
            dout      <= frame_next;
            shift_reg <= frame_next[14:0];
            datoDAC   <= frame_next[15];
            SYNC_out  <= 1'b0;
            ocupado   <= 1'b1;
            state     <= ENVIA;
          end
        end

        ENVIA: begin
          if (bit_count == 4'd15) begin
            SYNC_out  <= 1'b1;
            datoDAC   <= 1'b0;
            ocupado   <= 1'b0;
            listo     <= 1'b1;
            bit_count <= 4'd0;
            state     <= FIN;
          end else begin
            datoDAC   <= shift_reg[14];
            shift_reg <= {shift_reg[13:0], 1'b0};
            bit_count <= bit_count + 4'd1;
          end
        end

        FIN: begin
          listo <= 1'b0;
          state <= IDLE;
        end

        default: begin
          SYNC_out  <= 1'b1;
          datoDAC   <= 1'b0;
          ocupado   <= 1'b0;
          listo     <= 1'b0;
          bit_count <= 4'd0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
